// File: rtl/rom_reader_if.sv
// Command and output-stream bundle for rom_reader.
// Handshake rule for both channels: a transfer happens on a rising clk edge where
// valid and ready are both high; the sender keeps valid and its payload stable
// until that edge, and ready may depend on valid combinationally.
interface rom_reader_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 12
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [AW-1:0]    cmd_base;
    logic [AW:0]      cmd_cnt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_dat;
    logic             out_last;

    // Control logic / stream consumer side.
    modport master (
        output cmd_valid, cmd_base, cmd_cnt, out_ready,
        input  cmd_ready, out_valid, out_dat, out_last
    );

    // rom_reader side.
    modport slave (
        input  cmd_valid, cmd_base, cmd_cnt, out_ready,
        output cmd_ready, out_valid, out_dat, out_last
    );
endinterface

// File: rtl/rom_reader.sv
// Read sequencer for the lookup ROM: takes a (base, count) command, issues one
// ROM read per cycle under a 2-credit rule and streams the words out through a
// 2-entry buffer whose head register drives out_dat/out_last directly.
module rom_reader #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4096,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    rom_reader_if.slave      bus,
    output logic             rom_ren_o,
    output logic [AW-1:0]    rom_adr_o,
    input  logic [WIDTH-1:0] rom_dat_i,
    output logic             busy_o,
    output logic [1:0]       state_o,
    output logic [1:0]       occ_o
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    adr_q, adr_d;
    logic [AW:0]      rem_q, rem_d;
    logic             infl_q, infl_last_q;
    logic             hd_valid_q, hd_valid_d;
    logic             hd_last_q, hd_last_d;
    logic [WIDTH-1:0] hd_dat_q, hd_dat_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_last_q, s1_last_d;
    logic [WIDTH-1:0] s1_dat_q, s1_dat_d;

    logic       pop;
    logic       ren;
    logic       cmd_hs;
    logic [1:0] occ;

    // Occupancy counts a read in flight as already holding a buffer slot, so a
    // returning word always has somewhere to land.
    assign occ    = {1'b0, hd_valid_q} + {1'b0, s1_valid_q} + {1'b0, infl_q};
    assign pop    = hd_valid_q && bus.out_ready;
    assign ren    = !rst && (state_q == S_RUN) && (rem_q != '0) && ((occ < 2'd2) || pop);
    assign cmd_hs = !rst && (state_q == S_IDLE) && bus.cmd_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: zero-length commands are accepted but never leave IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_hs && (bus.cmd_cnt != '0)) state_d = S_RUN;
            S_RUN:   if (ren && (rem_q == (AW+1)'(1))) state_d = S_DRAIN;
            S_DRAIN: if (pop && hd_last_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state and the buffer head register.
    always_comb begin
        bus.cmd_ready = (state_q == S_IDLE) && !rst;
        busy_o        = (state_q != S_IDLE);
        rom_ren_o     = ren;
        rom_adr_o     = adr_q;
        bus.out_valid = hd_valid_q;
        bus.out_dat   = hd_dat_q;
        bus.out_last  = hd_last_q;
        state_o       = state_q;
        occ_o         = occ;
    end

    // Address/remaining-count update; the address wraps at DEPTH-1 even when
    // DEPTH is not a power of two.
    always_comb begin
        adr_d = adr_q;
        rem_d = rem_q;
        if (cmd_hs) begin
            adr_d = bus.cmd_base;
            rem_d = bus.cmd_cnt;
        end else if (ren) begin
            adr_d = (adr_q == AW'(DEPTH - 1)) ? '0 : adr_q + AW'(1);
            rem_d = rem_q - (AW+1)'(1);
        end
    end

    // Two-slot buffer: the head is the output register, s1 only fills when a
    // word returns while the head is held by backpressure.
    always_comb begin
        hd_valid_d = hd_valid_q;
        hd_last_d  = hd_last_q;
        hd_dat_d   = hd_dat_q;
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_dat_d   = s1_dat_q;
        if (hd_valid_q && !pop) begin
            if (infl_q) begin
                s1_valid_d = 1'b1;
                s1_last_d  = infl_last_q;
                s1_dat_d   = rom_dat_i;
            end
        end else if (s1_valid_q) begin
            hd_valid_d = 1'b1;
            hd_last_d  = s1_last_q;
            hd_dat_d   = s1_dat_q;
            s1_valid_d = infl_q;
            s1_last_d  = infl_last_q;
            s1_dat_d   = rom_dat_i;
        end else if (infl_q) begin
            hd_valid_d = 1'b1;
            hd_last_d  = infl_last_q;
            hd_dat_d   = rom_dat_i;
        end else begin
            hd_valid_d = 1'b0;
            hd_last_d  = 1'b0;
        end
    end

    // Datapath registers; reset also forgets any read still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            adr_q       <= '0;
            rem_q       <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            hd_valid_q  <= 1'b0;
            hd_last_q   <= 1'b0;
            hd_dat_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_dat_q    <= '0;
        end else begin
            adr_q       <= adr_d;
            rem_q       <= rem_d;
            infl_q      <= ren;
            infl_last_q <= ren && (rem_q == (AW+1)'(1));
            hd_valid_q  <= hd_valid_d;
            hd_last_q   <= hd_last_d;
            hd_dat_q    <= hd_dat_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_dat_q    <= s1_dat_d;
        end
    end
endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader with a behavioural 1-cycle ROM holding mem[i]=i[7:0].
module tb_rom_reader;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4096;
    localparam int AW    = 12;

    // Clock and reset.
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rom_reader_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    logic             rom_ren;
    logic [AW-1:0]    rom_adr;
    logic [WIDTH-1:0] rom_dat = '0;
    logic             busy;
    logic [1:0]       state;
    logic [1:0]       occ;

    rom_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .rom_ren_o (rom_ren),
        .rom_adr_o (rom_adr),
        .rom_dat_i (rom_dat),
        .busy_o    (busy),
        .state_o   (state),
        .occ_o     (occ)
    );

    // ROM model: registered read, data holds when not read.
    always @(posedge clk) if (rom_ren) rom_dat <= rom_adr[7:0];

    // Scoreboard.
    logic [WIDTH:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Driver tasks.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] a;
            a = AW'((base + i) % DEPTH);
            exp_q.push_back({(i == n - 1), a[7:0]});
        end
    endtask

    // Offers a command and returns 1 time unit after the accepting edge.
    task automatic send_cmd(input logic [AW-1:0] base, input logic [AW:0] cnt);
        int t;
        t = 0;
        bus.cmd_base  = base;
        bus.cmd_cnt   = cnt;
        bus.cmd_valid = 1'b1;
        #1;
        while (!bus.cmd_ready && t < 50) begin
            step();
            t++;
        end
        check("cmd_accept", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Consumes n words; mode 0 keeps out_ready high, mode 1 raises it one cycle in three.
    task automatic consume(input int n, input int mode);
        int got, cyc, stab_err, occ_err, ren_err;
        logic [WIDTH-1:0] prev_dat;
        logic prev_stall;
        got = 0; cyc = 0; stab_err = 0; occ_err = 0; ren_err = 0;
        prev_dat = '0; prev_stall = 1'b0;
        while (got < n && cyc < n * 4 + 20) begin
            bus.out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            #1;
            if (prev_stall && bus.out_dat !== prev_dat) stab_err++;
            if (occ > 2'd2) occ_err++;
            if (occ == 2'd2 && !(bus.out_valid && bus.out_ready) && rom_ren) ren_err++;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("extra_word", 32'd1, 32'd0);
                else check("word", 32'({bus.out_last, bus.out_dat}), 32'(exp_q.pop_front()));
                got++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_dat   = bus.out_dat;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("stream_count", 32'(got), 32'(n));
        check("stall_stable", 32'(stab_err), 32'd0);
        check("occ_max2", 32'(occ_err), 32'd0);
        check("ren_credit", 32'(ren_err), 32'd0);
    endtask

    initial begin
        int bad;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_cnt   = '0;
        bus.out_ready = 1'b0;
        step();
        check("rst_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rom_ren", 32'(rom_ren), 32'd0);
        check("rst_rom_adr", 32'(rom_adr), 32'd0);
        check("rst_out_dat", 32'(bus.out_dat), 32'd0);
        check("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Basic 4-word read with latency check.
        send_cmd(12'h010, 13'd4);
        bus.out_ready = 1'b1;
        #1;
        check("e0_ren", 32'(rom_ren), 32'd1);
        check("e0_adr", 32'(rom_adr), 32'h010);
        check("e0_busy", 32'(busy), 32'd1);
        check("e0_out_valid", 32'(bus.out_valid), 32'd0);
        step();
        check("e1_out_valid", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("basic_valid", 32'(bus.out_valid), 32'd1);
            check("basic_dat", 32'(bus.out_dat), 32'(8'h10 + i));
            check("basic_last", 32'(bus.out_last), 32'(i == 3));
        end
        step();
        check("basic_end_valid", 32'(bus.out_valid), 32'd0);
        check("basic_end_busy", 32'(busy), 32'd0);
        check("basic_end_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Address wrap at the top of the ROM.
        push_exp(12'hFFE, 4);
        send_cmd(12'hFFE, 13'd4);
        consume(4, 0);

        // Backpressure: ready high one cycle in three.
        push_exp(12'h040, 8);
        send_cmd(12'h040, 13'd8);
        consume(8, 1);
        check("bp_idle_after", 32'(busy), 32'd0);

        // Zero-length command produces nothing.
        send_cmd(12'h020, 13'd0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (rom_ren || bus.out_valid || busy || !bus.cmd_ready) bad++;
            step();
        end
        check("cnt0_quiet", 32'(bad), 32'd0);

        // Reset mid-command with the buffer full.
        bus.out_ready = 1'b0;
        send_cmd(12'h000, 13'd8);
        step();
        step();
        step();
        check("full_occ", 32'(occ), 32'd2);
        check("full_no_ren", 32'(rom_ren), 32'd0);
        check("full_head", 32'(bus.out_dat), 32'h00);
        bus.out_ready = 1'b1;
        #1;
        check("full_pop_ren", 32'(rom_ren), 32'd1);
        step();
        check("mid_word1", 32'(bus.out_dat), 32'h01);
        step();
        bus.out_ready = 1'b0;
        step();
        check("mid_occ", 32'(occ), 32'd2);
        check("mid_word3", 32'(bus.out_dat), 32'h02);
        rst = 1'b1;
        #1;
        check("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_last", 32'(bus.out_last), 32'd0);
        check("midrst_dat", 32'(bus.out_dat), 32'd0);
        check("midrst_ren", 32'(rom_ren), 32'd0);
        check("midrst_adr", 32'(rom_adr), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_occ", 32'(occ), 32'd0);
        check("midrst_cmd_ready1", 32'(bus.cmd_ready), 32'd1);
        exp_q.delete();
        push_exp(12'h100, 2);
        send_cmd(12'h100, 13'd2);
        consume(2, 0);

        // Full-depth command starting at 5.
        push_exp(5, DEPTH);
        send_cmd(12'd5, 13'd4096);
        consume(DEPTH, 0);
        check("full_busy_end", 32'(busy), 32'd0);
        check("full_cmd_ready_end", 32'(bus.cmd_ready), 32'd1);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        // Final report.
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
